// File: rtl/alu74181_seq_pkg.sv
// Shared types and constants for the nibble-serial 74181 sequencer.
package alu74181_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int         NIBBLE_W    = 4;
   localparam logic [3:0] S_ADD       = 4'b1001;
   localparam logic [3:0] S_SUB       = 4'b0110;
   localparam logic [3:0] S_XOR       = 4'b0110;  // same code as S_SUB, selected with M=1
   localparam logic       ALU_M_LOGIC = 1'b1;

   // Two's-complement overflow for the full-width add/subtract codes; other ops report 0.
   function automatic logic ovf_calc(input logic [3:0] s, input logic m,
                                     input logic a_msb, input logic b_msb,
                                     input logic f_msb);
      logic v;
      v = 1'b0;
      if (m != ALU_M_LOGIC) begin
         if (s == S_ADD)
            v = (a_msb == b_msb) && (f_msb != a_msb);
         else if (s == S_SUB)
            v = (a_msb != b_msb) && (f_msb != a_msb);
      end
      return v;
   endfunction

endpackage

// File: rtl/alu74181_nibble_seq.sv
// Nibble-serial sequencer: runs a 4*NIBBLES-bit operation through one external
// 74181 slice, LSB nibble first, chaining CN4b back into CNb each cycle.
// Optional macro ALU74181_SEQ_OVF_EN adds the ovf_o signed-overflow output.
//
//   state | meaning
//   IDLE  | waiting for start_i
//   RUN   | nibble k on the slice, capture F/AEB/CN4b at the edge
//   DONE  | one-cycle result-valid, start_i may relaunch immediately
module alu74181_nibble_seq
   import alu74181_seq_pkg::*;
#(
   parameter int NIBBLES = 4
) (
   input  logic                      wb_clk_i,
   input  logic                      wb_rst_i,
   input  logic                      start_i,
   input  logic [4*NIBBLES-1:0]      a_i,
   input  logic [4*NIBBLES-1:0]      b_i,
   input  logic [3:0]                s_i,
   input  logic                      m_i,
   input  logic                      cnb_i,
   output logic [3:0]                alu_a_o,
   output logic [3:0]                alu_b_o,
   output logic [3:0]                alu_s_o,
   output logic                      alu_m_o,
   output logic                      alu_cnb_o,
   input  logic [3:0]                alu_f_i,
   input  logic                      alu_aeb_i,
   input  logic                      alu_cn4b_i,
   output logic                      busy_o,
   output logic                      done_o,
   output logic [4*NIBBLES-1:0]      f_o,
   output logic                      cn4b_o,
   output logic                      aeb_o
`ifdef ALU74181_SEQ_OVF_EN
   ,
   output logic                      ovf_o
`endif
);

   localparam int              W      = NIBBLE_W * NIBBLES;
   localparam int              KW     = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [KW-1:0]   K_LAST = KW'(NIBBLES - 1);

   state_t          r_state;
   logic [KW-1:0]   r_k;
   logic [W-1:0]    r_a;
   logic [W-1:0]    r_b;
   logic [3:0]      r_s;
   logic            r_m;
   logic            r_carry;
   logic            r_aeb_acc;
   logic [W-1:0]    r_shadow;
   logic [W-1:0]    w_shadow_next;
   logic            w_last;

   // Slice inputs come straight from the latched operands; they hold their last value outside RUN.
   assign alu_a_o   = r_a[NIBBLE_W*r_k +: NIBBLE_W];
   assign alu_b_o   = r_b[NIBBLE_W*r_k +: NIBBLE_W];
   assign alu_s_o   = r_s;
   assign alu_m_o   = r_m;
   assign alu_cnb_o = r_carry;
   assign busy_o    = (r_state == RUN);
   assign done_o    = (r_state == DONE);
   assign w_last    = (r_k == K_LAST);

   // Result shadow with the current nibble's F merged in, so the last nibble lands in f_o on the same edge.
   always_comb begin
      w_shadow_next = r_shadow;
      w_shadow_next[NIBBLE_W*r_k +: NIBBLE_W] = alu_f_i;
   end

   // Sequencer FSM, operand latch, carry/AEB chaining and result publication.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_state   <= IDLE;
         r_k       <= '0;
         r_a       <= '0;
         r_b       <= '0;
         r_s       <= '0;
         r_m       <= ALU_M_LOGIC;
         r_carry   <= 1'b1;
         r_aeb_acc <= 1'b0;
         r_shadow  <= '0;
         f_o       <= '0;
         cn4b_o    <= 1'b1;
         aeb_o     <= 1'b0;
`ifdef ALU74181_SEQ_OVF_EN
         ovf_o     <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE, DONE: begin
               if (start_i) begin
                  r_a       <= a_i;
                  r_b       <= b_i;
                  r_s       <= s_i;
                  r_m       <= m_i;
                  r_carry   <= cnb_i;
                  r_aeb_acc <= 1'b1;
                  r_k       <= '0;
                  r_state   <= RUN;
               end else begin
                  r_state   <= IDLE;
               end
            end
            RUN: begin
               r_shadow  <= w_shadow_next;
               r_carry   <= alu_cn4b_i;
               r_aeb_acc <= r_aeb_acc & alu_aeb_i;
               if (w_last) begin
                  // k stays on the top nibble so the slice inputs hold their last value.
                  r_state <= DONE;
                  f_o     <= w_shadow_next;
                  cn4b_o  <= alu_cn4b_i;
                  aeb_o   <= r_aeb_acc & alu_aeb_i;
`ifdef ALU74181_SEQ_OVF_EN
                  ovf_o   <= ovf_calc(r_s, r_m, r_a[W-1], r_b[W-1], alu_f_i[NIBBLE_W-1]);
`endif
               end else begin
                  r_k <= r_k + 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/alu74181_nibble_seq.md
Name: alu74181_nibble_seq

Overview:
Nibble-serial sequencer that runs wide (4*NIBBLES-bit) operations through one external 4-bit 74181 ALU slice (top_alu74181), one nibble per cycle, LSB nibble first.
- Upstream: latches the operands and drives the slice's A/B/S/CNb/M.
- Downstream: captures F, AEB and CN4b, chaining CN4b into the next nibble's CNb.
- Sits between the user-project register/IO logic and the combinational ALU slice.

Parameters:
NIBBLES, 4, number of 4-bit slices per operation; operand width W = 4*NIBBLES; legal range 1..8.

Ports:
wb_clk_i  in  1  single clock, rising edge
wb_rst_i  in  1  synchronous reset, active-high
start_i  in  1  request; accepted when busy_o=0
a_i  in  W  operand A
b_i  in  W  operand B
s_i  in  4  74181 function select
m_i  in  1  mode, 1=logic, 0=arithmetic
cnb_i  in  1  carry-in to nibble 0, raw 74181 polarity (0 = carry)
alu_a_o  out  4  A nibble to slice
alu_b_o  out  4  B nibble to slice
alu_s_o  out  4  S to slice
alu_m_o  out  1  M to slice
alu_cnb_o  out  1  CNb to slice
alu_f_i  in  4  F from slice
alu_aeb_i  in  1  AEB from slice
alu_cn4b_i  in  1  CN4b from slice
busy_o  out  1  high while RUN
done_o  out  1  one-cycle result-valid pulse
f_o  out  W  assembled result
cn4b_o  out  1  carry-out of top nibble, raw polarity
aeb_o  out  1  AND of all nibble AEB values

Behaviour:
- FSM states: IDLE, RUN, DONE. Nibble index k is a counter of width clog2(NIBBLES), minimum 1 bit.
- Reset values: state=IDLE, k=0, busy_o=0, done_o=0, f_o=0, cn4b_o=1, aeb_o=0, alu_a_o=0, alu_b_o=0, alu_s_o=0, alu_m_o=1, alu_cnb_o=1.
- Accept: start_i=1 in IDLE or DONE.
  - On that edge, latch a_i, b_i, s_i, m_i, cnb_i; set carry reg = cnb_i and aeb accumulator = 1; k=0; go to RUN.
  - start_i while in RUN is ignored; there is no queue.
- RUN, cycle k:
  - Drive alu_a_o=A[4k+3:4k], alu_b_o=B[4k+3:4k], alu_s_o and alu_m_o from the latched values, alu_cnb_o = carry reg. These are combinational from registers.
  - At the edge: store alu_f_i into the result shadow [4k+3:4k]; carry reg = alu_cn4b_i; aeb acc &= alu_aeb_i; k++.
  - After k=NIBBLES-1, go to DONE.
- DONE (exactly 1 cycle): done_o=1. f_o, cn4b_o and aeb_o are updated from the shadow/regs on entry to DONE and held until the next DONE.
- Latency: start accepted in cycle 0 → RUN cycles 1..NIBBLES → done_o in cycle NIBBLES+1.
- Throughput: back-to-back when start_i is high in the DONE cycle; one operation per NIBBLES+1 cycles.
- busy_o=1 only in RUN. In IDLE/DONE the alu_* outputs hold their last values (don't-care for consumers).
- M=1: the carry chain still runs and cn4b_o is reported, but it is meaningless for logic functions.
- Reset mid-RUN: abort immediately, no done_o, all outputs return to reset values.

Optional Feature:
ALU74181_SEQ_OVF_EN
- Defined: adds output ovf_o (1 bit, reset 0), updated on entry to DONE, 0 for all other ops.
  - S=1001 with M=0 (add): ovf_o = (a[W-1]==b[W-1]) && (f[W-1]!=a[W-1]).
  - S=0110 with M=0 (subtract): ovf_o = (a[W-1]!=b[W-1]) && (f[W-1]!=a[W-1]).
- Undefined: the port and its logic are absent.

Decomposition:
- Package alu74181_seq_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - constants NIBBLE_W=4, S_ADD=4'b1001, S_SUB=4'b0110, S_XOR=4'b0110 (logic), ALU_M_LOGIC=1'b1.
- No sub-module: the nibble mux and capture logic stay inline. The ALU slice is instantiated beside this block by the integrating top, not inside it.

Test Plan (NIBBLES=4, bench wraps a real top_alu74181):
1. Add: a=0x1234, b=0x0FFF, s=1001, m=0, cnb=1 → f_o=0x2233, cn4b_o=1, done_o exactly 5 cycles after start, busy_o high cycles 1–4.
2. Carry wrap: a=0xFFFF, b=0x0001, add, cnb=1 → f_o=0x0000, cn4b_o=0. With OVF_EN: a=0x7FFF, b=0x0001 → f_o=0x8000, ovf_o=1.
3. Compare/subtract:
   - a=b=0xBEEF, s=0110, m=0, cnb=1 (A−B−1) → f_o=0xFFFF, aeb_o=1.
   - a=0x5000, b=0x0001, cnb=0 (A−B) → f_o=0x4FFF, cn4b_o=0, aeb_o=0.
4. Logic: a=0xF0F0, b=0xFF00, s=0110, m=1 → f_o=0x0FF0; alu_m_o=1 on every RUN cycle.
5. Handshake: pulse start_i again in cycle 2 with different operands → ignored, first result unchanged. Hold start_i high through DONE → second op accepted, second done_o 5 cycles later.
6. Reset: assert wb_rst_i for 1 cycle in RUN cycle 2 → no done_o, f_o=0, busy_o=0, aeb_o=0, cn4b_o=1. A new start then completes normally.
